// File: rtl/approx_pkg.sv
// Shared definitions for the dynamic approximate adder pipeline:
// the per-beat mode encoding, default parameter values and a majority helper.
package approx_pkg;

    typedef enum logic [1:0] {
        MODE_EXACT = 2'b00,   // full ripple add with carry-in
        MODE_CUT   = 2'b01,   // exact lower region, XOR-only upper region
        MODE_OR    = 2'b10,   // OR'd LSBs, exact add above them
        MODE_SPEC  = 2'b11    // OR'd LSBs, one-bit speculative carries above CUT
    } mode_e;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_CUT     = 4;
    localparam int DEF_OR_BITS = 1;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/approx_adder_core.sv
// Combinational approximate adder: produces the sum/carry for the selected
// mode alongside the exact {cout,sum} so the error can be measured later.
module approx_adder_core
    import approx_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CUT     = DEF_CUT,
    parameter int OR_BITS = DEF_OR_BITS
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH:0]   exact
);

    localparam int HI_W = WIDTH - OR_BITS;   // bits above the OR'd LSBs
    localparam int UP_W = WIDTH - CUT;       // bits in the upper region

    logic [CUT-1:0]     cut_lo;
    logic [WIDTH-1:0]   cut_sum;
    logic [OR_BITS-1:0] or_lo;
    logic [HI_W:0]      or_hi;
    logic [WIDTH-1:0]   or_sum;
    logic [UP_W-1:0]    spec_up;
    logic [WIDTH-1:0]   spec_sum;
    logic               spec_cout;

    assign exact = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

    // Carry-cut: lower region adds with cin and its carry is thrown away.
    assign cut_lo  = a[CUT-1:0] + b[CUT-1:0] + {{(CUT-1){1'b0}}, cin};
    assign cut_sum = {a[WIDTH-1:CUT] ^ b[WIDTH-1:CUT], cut_lo};

    // Lower-OR: LSBs are OR'd, the rest is an exact add with no carry-in.
    assign or_lo  = a[OR_BITS-1:0] | b[OR_BITS-1:0];
    assign or_hi  = {1'b0, a[WIDTH-1:OR_BITS]} + {1'b0, b[WIDTH-1:OR_BITS]};
    assign or_sum = {or_hi[HI_W-1:0], or_lo};

    // Speculative carry: each upper bit only looks at the generate of the bit below.
    generate
        for (genvar gi = 0; gi < UP_W; gi++) begin : g_spec
            assign spec_up[gi] = a[CUT+gi] ^ b[CUT+gi] ^ (a[CUT+gi-1] & b[CUT+gi-1]);
        end
    endgenerate

    // The lower region of the speculative mode equals the lower-OR result
    // truncated at CUT, since carries there only propagate upwards.
    assign spec_sum  = {spec_up, or_sum[CUT-1:0]};
    assign spec_cout = maj3(a[WIDTH-1], b[WIDTH-1], a[WIDTH-2] & b[WIDTH-2]);

    // Select the result for the beat's mode.
    always_comb begin
        sum  = exact[WIDTH-1:0];
        cout = exact[WIDTH];
        case (mode_e'(mode))
            MODE_EXACT: begin
                sum  = exact[WIDTH-1:0];
                cout = exact[WIDTH];
            end
            MODE_CUT: begin
                sum  = cut_sum;
                cout = 1'b0;
            end
            MODE_OR: begin
                sum  = or_sum;
                cout = or_hi[HI_W];
            end
            MODE_SPEC: begin
                sum  = spec_sum;
                cout = spec_cout;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dyn_approx_adder_pipe.sv
// Two-stage valid/ready pipeline around approx_adder_core.
// S1 registers the operand beat, S2 registers the result.
// Optional error monitor enabled by defining DYN_APPROX_ERR_MON_EN.
module dyn_approx_adder_pipe
    import approx_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CUT     = DEF_CUT,
    parameter int OR_BITS = DEF_OR_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       out_mode
`ifdef DYN_APPROX_ERR_MON_EN
    ,
    input  logic             stat_clr,
    output logic [31:0]      err_acc,
    output logic [WIDTH:0]   err_max,
    output logic [31:0]      txn_cnt
`endif
);

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic             s1_cin_reg;
    logic [1:0]       s1_mode_reg;

    logic             s2_valid_reg;
    logic [WIDTH-1:0] s2_sum_reg;
    logic             s2_cout_reg;
    logic [1:0]       s2_mode_reg;

    logic             s1_advance;
    logic             s2_advance;
    logic             in_xfer;
    logic             out_xfer;

    logic [WIDTH-1:0] core_sum;
    logic             core_cout;
    logic [WIDTH:0]   core_exact;

    // A stage may load when it is empty or its content moves on this cycle.
    assign s2_advance = !s2_valid_reg || out_ready;
    assign s1_advance = !s1_valid_reg || s2_advance;
    // Held low during reset so nothing is accepted while the pipe is cleared.
    assign in_ready   = !rst && s1_advance;
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = s2_valid_reg && out_ready;

    assign out_valid  = s2_valid_reg;
    assign sum        = s2_sum_reg;
    assign cout       = s2_cout_reg;
    assign out_mode   = s2_mode_reg;

    // S1: capture the operand beat and its mode on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_cin_reg   <= 1'b0;
            s1_mode_reg  <= 2'b00;
        end else if (s1_advance) begin
            s1_valid_reg <= in_valid;
            if (in_xfer) begin
                s1_a_reg    <= a;
                s1_b_reg    <= b;
                s1_cin_reg  <= cin;
                s1_mode_reg <= mode;
            end
        end
    end

    approx_adder_core #(
        .WIDTH   (WIDTH),
        .CUT     (CUT),
        .OR_BITS (OR_BITS)
    ) u_core (
        .a     (s1_a_reg),
        .b     (s1_b_reg),
        .cin   (s1_cin_reg),
        .mode  (s1_mode_reg),
        .sum   (core_sum),
        .cout  (core_cout),
        .exact (core_exact)
    );

    // S2: register the result; contents hold while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_sum_reg   <= '0;
            s2_cout_reg  <= 1'b0;
            s2_mode_reg  <= 2'b00;
        end else if (s2_advance) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_sum_reg  <= core_sum;
                s2_cout_reg <= core_cout;
                s2_mode_reg <= s1_mode_reg;
            end
        end
    end

`ifdef DYN_APPROX_ERR_MON_EN
    // Wide enough to hold a 32-bit accumulator plus one error term without wrap.
    localparam int ACC_W = (WIDTH + 2 > 33) ? WIDTH + 2 : 33;

    logic [WIDTH:0]  s2_exact_reg;
    logic [WIDTH:0]  approx_val;
    logic [WIDTH:0]  err_val;
    logic [ACC_W-1:0] acc_sum;
    logic [31:0]     err_acc_reg;
    logic [WIDTH:0]  err_max_reg;
    logic [31:0]     txn_cnt_reg;

    // Exact result travels alongside the approximate one through S2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_exact_reg <= '0;
        end else if (s2_advance && s1_valid_reg) begin
            s2_exact_reg <= core_exact;
        end
    end

    assign approx_val = {s2_cout_reg, s2_sum_reg};
    assign err_val    = (s2_exact_reg >= approx_val) ? (s2_exact_reg - approx_val)
                                                     : (approx_val - s2_exact_reg);
    assign acc_sum    = ACC_W'(err_acc_reg) + ACC_W'(err_val);

    // Statistics update on each result transfer; clear wins over a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_acc_reg <= '0;
            err_max_reg <= '0;
            txn_cnt_reg <= '0;
        end else if (stat_clr) begin
            err_acc_reg <= '0;
            err_max_reg <= '0;
            txn_cnt_reg <= '0;
        end else if (out_xfer) begin
            err_acc_reg <= (acc_sum > ACC_W'(32'hFFFF_FFFF)) ? 32'hFFFF_FFFF : acc_sum[31:0];
            if (err_val > err_max_reg) begin
                err_max_reg <= err_val;
            end
            if (txn_cnt_reg != 32'hFFFF_FFFF) begin
                txn_cnt_reg <= txn_cnt_reg + 32'd1;
            end
        end
    end

    assign err_acc = err_acc_reg;
    assign err_max = err_max_reg;
    assign txn_cnt = txn_cnt_reg;
`else
    // The exact sum only feeds the error monitor; fold it away otherwise.
    logic unused_exact;
    logic unused_out_xfer;
    assign unused_exact    = ^core_exact;
    assign unused_out_xfer = out_xfer;
`endif

endmodule

// File: tb/tb_dyn_approx_adder_pipe.sv
// Self-checking bench for dyn_approx_adder_pipe: hand-computed vector table,
// stall/reset sequences and a randomized run against a reference model.
// Define DYN_APPROX_ERR_MON_EN to also check the error monitor.
module tb_dyn_approx_adder_pipe;

    localparam int W   = 16;
    localparam int CUT = 4;
    localparam int ORB = 1;
    localparam int NB  = 300;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [1:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic [1:0]   out_mode;
`ifdef DYN_APPROX_ERR_MON_EN
    logic         stat_clr;
    logic [31:0]  err_acc;
    logic [W:0]   err_max;
    logic [31:0]  txn_cnt;
`endif

    always #5 clk = ~clk;

    dyn_approx_adder_pipe #(
        .WIDTH   (W),
        .CUT     (CUT),
        .OR_BITS (ORB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .out_mode  (out_mode)
`ifdef DYN_APPROX_ERR_MON_EN
        ,
        .stat_clr  (stat_clr),
        .err_acc   (err_acc),
        .err_max   (err_max),
        .txn_cnt   (txn_cnt)
`endif
    );

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic [1:0]   vmode;
        logic [W-1:0] vsum;
        logic         vcout;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic [1:0]   mode;
        logic [W:0]   exact;
    } res_t;

    vec_t        vecs[9];
    res_t        exp_q[$];
    res_t        held;
    logic        hold_pending = 1'b0;
    logic        last_acc = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          acc_cnt = 0;
    int          rcv_cnt = 0;
    longint unsigned mon_acc = 0;
    longint unsigned mon_max = 0;
    longint unsigned mon_txn = 0;
    logic [W-1:0] ba[4];
    logic [W-1:0] bb[4];

    // Reference: each mode derived from its arithmetic definition on whole words.
    function automatic res_t ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                       input logic rcin, input logic [1:0] rmode);
        longint unsigned ua, ub, wmask, cmask, omask, t, h;
        int votes;
        res_t r;
        ua    = 64'(ra);
        ub    = 64'(rb);
        wmask = (64'd1 << W) - 64'd1;
        cmask = (64'd1 << CUT) - 64'd1;
        omask = (64'd1 << ORB) - 64'd1;
        r.exact = (W+1)'(ua + ub + 64'(rcin));
        r.mode  = rmode;
        case (rmode)
            2'd0: begin
                t = ua + ub + 64'(rcin);
                r.sum  = W'(t);
                r.cout = t[W];
            end
            2'd1: begin
                t = (((ua & cmask) + (ub & cmask) + 64'(rcin)) & cmask) | ((ua ^ ub) & wmask & ~cmask);
                r.sum  = W'(t);
                r.cout = 1'b0;
            end
            2'd2: begin
                h = (ua >> ORB) + (ub >> ORB);
                t = ((h << ORB) | ((ua | ub) & omask)) & wmask;
                r.sum  = W'(t);
                r.cout = h[W-ORB];
            end
            default: begin
                h = (ua >> ORB) + (ub >> ORB);
                t = (((h << ORB) | ((ua | ub) & omask)) & cmask)
                  | ((ua ^ ub ^ ((ua & ub) << 1)) & wmask & ~cmask);
                votes  = int'(ra[W-1]) + int'(rb[W-1]) + int'(ra[W-2] & rb[W-2]);
                r.sum  = W'(t);
                r.cout = (votes >= 2);
            end
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corners[4];
        corners[0] = '0;
        corners[1] = '1;
        corners[2] = 16'h8000;
        corners[3] = 16'h7FFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
        return W'($urandom);
    endfunction

    // One cycle: sample outputs just after the falling edge, score transfers,
    // record accepts, then advance to the next falling edge.
    task automatic step();
        res_t e;
        longint unsigned ev, approx;
        #1;
        if (hold_pending && out_valid) begin
            check("hold_sum", 64'(sum), 64'(held.sum));
            check("hold_cout", 64'(cout), 64'(held.cout));
            check("hold_mode", 64'(out_mode), 64'(held.mode));
        end
        hold_pending = out_valid && !out_ready;
        held.sum  = sum;
        held.cout = cout;
        held.mode = out_mode;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got sum 0x%0h, expected no result", sum);
            end else begin
                e = exp_q.pop_front();
                check("sum", 64'(sum), 64'(e.sum));
                check("cout", 64'(cout), 64'(e.cout));
                check("out_mode", 64'(out_mode), 64'(e.mode));
                approx = 64'(e.sum) + (64'(e.cout) << W);
                ev = (64'(e.exact) >= approx) ? 64'(e.exact) - approx : approx - 64'(e.exact);
                mon_acc += ev;
                if (ev > mon_max) mon_max = ev;
                mon_txn++;
            end
            rcv_cnt++;
        end
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            exp_q.push_back(ref_model(a, b, cin, mode));
            acc_cnt++;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; mode = 2'b00; out_ready = 1'b0;
`ifdef DYN_APPROX_ERR_MON_EN
        stat_clr = 1'b0;
`endif
        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 2'd0, 16'h0100, 1'b0};
        vecs[1] = '{16'h000F, 16'h0001, 1'b0, 2'd1, 16'h0000, 1'b0};
        vecs[2] = '{16'h0001, 16'h0001, 1'b1, 2'd2, 16'h0001, 1'b0};
        vecs[3] = '{16'h0008, 16'h0008, 1'b0, 2'd3, 16'h0010, 1'b0};
        vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 2'd3, 16'hFFFF, 1'b0};
        vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, 2'd0, 16'h0000, 1'b1};
        vecs[6] = '{16'hFFFF, 16'h0001, 1'b1, 2'd1, 16'hFFF1, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 2'd2, 16'h0000, 1'b1};
        vecs[8] = '{16'hC000, 16'h4000, 1'b0, 2'd3, 16'h0000, 1'b1};

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_out_mode", 64'(out_mode), 64'd0);
`ifdef DYN_APPROX_ERR_MON_EN
        check("rst_err_acc", 64'(err_acc), 64'd0);
        check("rst_txn_cnt", 64'(txn_cnt), 64'd0);
`endif
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Table vectors: single beats, latency and no duplication.
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            a = vecs[i].va; b = vecs[i].vb; cin = vecs[i].vcin; mode = vecs[i].vmode;
            in_valid = 1'b1;
            #1;
            check("vec_in_ready", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
            check("vec_lat1_out_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
            check("vec_lat2_out_valid", 64'(out_valid), 64'd1);
            check("vec_sum", 64'(sum), 64'(vecs[i].vsum));
            check("vec_cout", 64'(cout), 64'(vecs[i].vcout));
            check("vec_out_mode", 64'(out_mode), 64'(vecs[i].vmode));
            @(negedge clk);
            check("vec_no_dup", 64'(out_valid), 64'd0);
        end

        // Back-to-back beats in all four modes with the consumer stalled.
        for (int i = 0; i < 4; i++) begin
            ba[i] = pick();
            bb[i] = pick();
        end
        exp_q.delete(); acc_cnt = 0; rcv_cnt = 0; hold_pending = 1'b0;
        for (int c = 0; c < 40 && rcv_cnt < 4; c++) begin
            in_valid = (acc_cnt < 4);
            if (acc_cnt < 4) begin
                a = ba[acc_cnt]; b = bb[acc_cnt]; cin = acc_cnt[0]; mode = 2'(acc_cnt);
            end
            out_ready = (c >= 5);
            if (c == 2) begin
                #1;
                check("stall_in_ready", 64'(in_ready), 64'd0);
                check("stall_accepts", 64'(acc_cnt), 64'd2);
            end
            step();
        end
        in_valid = 1'b0;
        check("burst_received", 64'(rcv_cnt), 64'd4);

        // Reset with two beats in flight.
        exp_q.delete(); out_ready = 1'b0; in_valid = 1'b1;
        a = 16'h1234; b = 16'h1111; cin = 1'b0; mode = 2'd0;
        step();
        a = 16'h4321; b = 16'h2222; mode = 2'd3;
        step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        check("midrst_out_mode", 64'(out_mode), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete(); hold_pending = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("no_stale_result", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
`ifdef DYN_APPROX_ERR_MON_EN
        check("midrst_err_acc", 64'(err_acc), 64'd0);
        check("midrst_txn_cnt", 64'(txn_cnt), 64'd0);

        // Error monitor: one lower-OR beat, then clear.
        in_valid = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b1; mode = 2'd2;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("mon_err_acc", 64'(err_acc), 64'd2);
        check("mon_err_max", 64'(err_max), 64'd2);
        check("mon_txn_cnt", 64'(txn_cnt), 64'd1);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        check("clr_err_acc", 64'(err_acc), 64'd0);
        check("clr_err_max", 64'(err_max), 64'd0);
        check("clr_txn_cnt", 64'(txn_cnt), 64'd0);
`endif

        // Randomized traffic with random back-pressure.
        exp_q.delete(); acc_cnt = 0; rcv_cnt = 0; hold_pending = 1'b0;
        mon_acc = 0; mon_max = 0; mon_txn = 0;
        in_valid = 1'b0; last_acc = 1'b0;
        for (int c = 0; c < 4000 && rcv_cnt < NB; c++) begin
            if (acc_cnt >= NB) begin
                in_valid = 1'b0;
            end else if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 9) < 7);
                a = pick(); b = pick(); cin = 1'($urandom); mode = 2'($urandom);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        in_valid = 1'b0;
        check("random_received", 64'(rcv_cnt), 64'(NB));
        check("random_queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef DYN_APPROX_ERR_MON_EN
        check("random_err_acc", 64'(err_acc), (mon_acc > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mon_acc);
        check("random_err_max", 64'(err_max), mon_max);
        check("random_txn_cnt", 64'(txn_cnt), mon_txn);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
